hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Decode-stage scoreboard in front of the 16x16-bit register file. Tracks in-flight writers per
//  architectural register: increments on issue from decode, decrements on writeback retire (the
//  regfile write port). Flags read-after-write hazards on the two decode source operands and
//  raises stall to hold IF/ID until the pending writes reach the register file.
// PARAMETERS
//  NREG   16  number of architectural registers (index width = 4)
//  CNT_W  2   width of each per-register pending counter; max in-flight writers = 2**CNT_W-1
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      asynchronous reset, active high
//  issue_valid  in   1      decode holds a valid instruction ready to issue
//  issue_we     in   1      issuing instruction writes a register
//  issue_dst    in   4      destination register of issuing instruction
//  src1         in   4      decode source register 1 (same index driven to regfile Src1)
//  src1_used    in   1      instruction actually reads src1
//  src2         in   4      decode source register 2 (same index driven to regfile Src2)
//  src2_used    in   1      instruction actually reads src2
//  flush        in   1      squash the instruction in decode (branch taken); suppresses issue
//  retire_we    in   1      writeback writes regfile this cycle (same signal as regfile we)
//  retire_dst   in   4      writeback destination (same signal as regfile Dst)
//  stall        out  1      hold IF/ID; decode instruction must not issue
//  src1_busy    out  1      src1 has a pending writer
//  src2_busy    out  1      src2 has a pending writer
//  busy_vec     out  16     bit i = pending counter of register i nonzero
//  err          out  1      sticky: retire to a register with zero pending count
// BEHAVIOUR
//  - State: NREG counters cnt[i] of CNT_W bits plus err flag; all reset to 0 asynchronously.
//    Reset values: stall=0, src*_busy=0, busy_vec=0, err=0.
//  - Register 0: cnt[0] is never incremented or decremented; busy_vec[0], and src*_busy for
//    index 0, are always 0. Retire to R0 never sets err.
//  - Combinational outputs from current cnt: srcN_busy = srcN!=0 && cnt[srcN]!=0.
//    dst_full = issue_we && issue_dst!=0 && cnt[issue_dst]==2**CNT_W-1.
//    stall = issue_valid && !flush && ((src1_used && src1_busy) || (src2_used && src2_busy) || dst_full).
//  - issue_fire = issue_valid && !flush && !stall. inc = issue_fire && issue_we && issue_dst!=0.
//  - dec = retire_we && retire_dst!=0 && cnt[retire_dst]!=0.
//  - Next state per register i (one clock latency, visible next cycle):
//    inc and dec same register -> cnt unchanged; inc only -> +1; dec only -> -1.
//  - Underflow: retire_we, retire_dst!=0, cnt==0 -> cnt held at 0, err set; err clears only on rst.
//  - Saturation: counter never wraps; dst_full stalls issue instead of incrementing past max.
//  - flush has priority over issue: no increment, stall forced 0 that cycle; retire unaffected.
//  - Issue whose dst equals its own src: hazard check uses pre-issue cnt; own write is not a hazard.
//  - rst asserted mid-operation clears all counters immediately; in-flight writers later retiring
//    against cnt==0 set err (pipeline must be reset together with the scoreboard).
// CONFIGURATION
//  SCOREBOARD_WB_BYPASS_EN defined: regfile write-before-read bypass is honoured. A source is not
//    busy when retire_we && retire_dst==srcN && cnt[srcN]==1 (last writer retiring this cycle);
//    stall and srcN_busy drop in the retire cycle. Likewise dst_full ignores a same-cycle
//    decrement of issue_dst. busy_vec stays purely registered.
//  Not defined: busy/stall computed from registered cnt only; a consumer of the last pending
//    write stalls one extra cycle and issues the cycle after retire.
// TESTING
//  1. rst pulse mid-run with cnt[3]=2 -> all outputs 0 asynchronously; later retire R3 -> err=1.
//  2. Issue we dst=R5; next cycle src1=R5 used -> stall=1, src1_busy=1, busy_vec=16'h0020;
//     retire R5 -> without macro stall=0 next cycle; with macro stall=0 in retire cycle.
//  3. Issue dst=R2 three times (CNT_W=2) -> cnt=3; fourth issue dst=R2 -> stall=1, cnt stays 3;
//     retire R2 + new issue R2 same cycle -> cnt stays 3 (macro) / stall held (no macro).
//  4. Issue dst=R0, src1=R0 used, retire R0 -> busy_vec=0, stall=0, err=0.
//  5. issue_valid with src2=R7 busy and flush=1 -> stall=0, no increment; cnt[7] unchanged.
//  6. Retire R9 with cnt[9]=0 -> err=1 and stays 1; cnt[9]=0; other counters unchanged.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW scoreboard: per-register pending-writer counters, source busy flags and a decode stall.
// Latency: busy/stall are combinational from the current counters; counter updates are visible one clock later.
// Backpressure: stall holds IF/ID while a used source is busy or the destination counter is saturated.
//               flush wins over issue and forces stall low.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   issue_valid/we/dst       instruction in decode; it increments cnt[dst] when it issues
//   src1/src1_used           first decode source operand
//   src2/src2_used           second decode source operand
//   flush                    squashes the decode instruction (no issue, no stall)
//   retire_we/retire_dst     regfile write port; decrements cnt[dst]
//   stall                    hold IF/ID
//   src1_busy, src2_busy     the source has a pending writer
//   busy_vec                 bit i set when cnt[i] != 0
//   err                      sticky flag: a retire hit a register with no pending writer
//
// Build option: define SCOREBOARD_WB_BYPASS_EN to let a source (and a saturated destination)
// see the same-cycle retire. The regfile forwards its write to reads in that cycle.
module hazard_scoreboard #(
  parameter int NREG  = 16,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic            issue_we,
  input  logic [3:0]      issue_dst,
  input  logic [3:0]      src1,
  input  logic            src1_used,
  input  logic [3:0]      src2,
  input  logic            src2_used,
  input  logic            flush,
  input  logic            retire_we,
  input  logic [3:0]      retire_dst,
  output logic            stall,
  output logic            src1_busy,
  output logic            src2_busy,
  output logic [NREG-1:0] busy_vec,
  output logic            err
);

  localparam int IDX_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             err_q, err_d;

  logic dst_full;
  logic issue_fire;
  logic inc;
  logic dec;
  logic underflow;

  // Hazard detection and issue/retire qualification
  always_comb begin
    src1_busy  = (src1 != '0) && (cnt_q[src1] != '0);
    src2_busy  = (src2 != '0) && (cnt_q[src2] != '0);
    dst_full   = issue_we && (issue_dst != '0) && (cnt_q[issue_dst] == CNT_MAX);
`ifdef SCOREBOARD_WB_BYPASS_EN
    // Last pending writer retires this cycle; the regfile forwards it, so the source is ready.
    if (retire_we && (retire_dst == src1) && (cnt_q[src1] == CNT_ONE)) src1_busy = 1'b0;
    if (retire_we && (retire_dst == src2) && (cnt_q[src2] == CNT_ONE)) src2_busy = 1'b0;
    // A saturated destination that drops by one this cycle has room for the new writer.
    if (retire_we && (retire_dst == issue_dst) && (cnt_q[issue_dst] != '0)) dst_full = 1'b0;
`endif
    stall      = issue_valid && !flush &&
                 ((src1_used && src1_busy) || (src2_used && src2_busy) || dst_full);
    issue_fire = issue_valid && !flush && !stall;
    inc        = issue_fire && issue_we && (issue_dst != '0);
    dec        = retire_we && (retire_dst != '0) && (cnt_q[retire_dst] != '0);
    underflow  = retire_we && (retire_dst != '0) && (cnt_q[retire_dst] == '0);
  end

  // Counter next state; R0 is hardwired to zero and never tracked
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i != 0) begin
        if (inc && (issue_dst == IDX_W'(i)) && !(dec && (retire_dst == IDX_W'(i))))
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        else if (dec && (retire_dst == IDX_W'(i)) && !(inc && (issue_dst == IDX_W'(i))))
          cnt_d[i] = cnt_q[i] - CNT_ONE;
      end else begin
        cnt_d[i] = '0;
      end
    end
    err_d = err_q | underflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) busy_vec[i] = (i != 0) && (cnt_q[i] != '0);
    err = err_q;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid, issue_we, src1_used, src2_used, flush, retire_we;
  logic [3:0]  issue_dst, src1, src2, retire_dst;
  logic        stall, src1_busy, src2_busy, err;
  logic [15:0] busy_vec;

  int tests_run = 0;
  int tests_failed = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_dst(issue_dst),
    .src1(src1), .src1_used(src1_used), .src2(src2), .src2_used(src2_used),
    .flush(flush), .retire_we(retire_we), .retire_dst(retire_dst),
    .stall(stall), .src1_busy(src1_busy), .src2_busy(src2_busy),
    .busy_vec(busy_vec), .err(err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    issue_valid = 0; issue_we = 0; issue_dst = 0;
    src1 = 0; src1_used = 0; src2 = 0; src2_used = 0;
    flush = 0; retire_we = 0; retire_dst = 0;
  endtask

  // Advance one clock; inputs change and outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    #1 rst = 1'b1;
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b expected 0", stall); end
    tests_run++; if ({src1_busy, src2_busy} !== 2'b00) begin tests_failed++; $display("FAIL reset_busy: got %b expected 00", {src1_busy, src2_busy}); end
    tests_run++; if (busy_vec !== 16'h0000) begin tests_failed++; $display("FAIL reset_busy_vec: got %h expected 0000", busy_vec); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_raw();
    idle();
    issue_valid = 1; issue_we = 1; issue_dst = 4'd5;
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL raw_producer_stall: got %b expected 0", stall); end
    step();
    idle();
    issue_valid = 1; src1 = 4'd5; src1_used = 1;
    #1;
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL raw_consumer_stall: got %b expected 1", stall); end
    tests_run++; if (src1_busy !== 1'b1) begin tests_failed++; $display("FAIL raw_src1_busy: got %b expected 1", src1_busy); end
    tests_run++; if (busy_vec !== 16'h0020) begin tests_failed++; $display("FAIL raw_busy_vec: got %h expected 0020", busy_vec); end
    step();
    retire_we = 1; retire_dst = 4'd5;
    #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL raw_retire_cycle_stall: got %b expected 0", stall); end
    tests_run++; if (src1_busy !== 1'b0) begin tests_failed++; $display("FAIL raw_retire_cycle_busy: got %b expected 0", src1_busy); end
`else
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL raw_retire_cycle_stall: got %b expected 1", stall); end
    tests_run++; if (src1_busy !== 1'b1) begin tests_failed++; $display("FAIL raw_retire_cycle_busy: got %b expected 1", src1_busy); end
`endif
    step();
    retire_we = 0;
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL raw_after_retire_stall: got %b expected 0", stall); end
    tests_run++; if (busy_vec !== 16'h0000) begin tests_failed++; $display("FAIL raw_after_retire_vec: got %h expected 0000", busy_vec); end
    step();
    idle();
  endtask

  task automatic test_saturation();
    int drains;
    idle();
    issue_valid = 1; issue_we = 1; issue_dst = 4'd2;
    step(); step(); step();
    #1;
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL sat_fourth_stall: got %b expected 1", stall); end
    tests_run++; if (busy_vec !== 16'h0004) begin tests_failed++; $display("FAIL sat_busy_vec: got %h expected 0004", busy_vec); end
    step();
    retire_we = 1; retire_dst = 4'd2;
    #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL sat_retire_issue_stall: got %b expected 0", stall); end
    drains = 3;
`else
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL sat_retire_issue_stall: got %b expected 1", stall); end
    drains = 2;
`endif
    step();
    issue_valid = 0; issue_we = 0;
    // Counter never passed 3, so exactly 'drains' more retires empty it.
    for (int k = 1; k < drains; k++) step();
    #1;
    tests_run++; if (busy_vec[2] !== 1'b1) begin tests_failed++; $display("FAIL sat_drain_early: got %b expected 1", busy_vec[2]); end
    step();
    retire_we = 0;
    #1;
    tests_run++; if (busy_vec[2] !== 1'b0) begin tests_failed++; $display("FAIL sat_drain_done: got %b expected 0", busy_vec[2]); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL sat_err: got %b expected 0", err); end
    idle();
  endtask

  task automatic test_r0();
    idle();
    issue_valid = 1; issue_we = 1; issue_dst = 4'd0;
    src1 = 4'd0; src1_used = 1; src2 = 4'd0; src2_used = 1;
    retire_we = 1; retire_dst = 4'd0;
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL r0_stall: got %b expected 0", stall); end
    tests_run++; if (src1_busy !== 1'b0) begin tests_failed++; $display("FAIL r0_src1_busy: got %b expected 0", src1_busy); end
    step(); step();
    idle();
    #1;
    tests_run++; if (busy_vec !== 16'h0000) begin tests_failed++; $display("FAIL r0_busy_vec: got %h expected 0000", busy_vec); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL r0_err: got %b expected 0", err); end
  endtask

  task automatic test_flush();
    idle();
    issue_valid = 1; issue_we = 1; issue_dst = 4'd7;
    step();
    src2 = 4'd7; src2_used = 1; flush = 1;
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL flush_stall: got %b expected 0", stall); end
    tests_run++; if (src2_busy !== 1'b1) begin tests_failed++; $display("FAIL flush_src2_busy: got %b expected 1", src2_busy); end
    step();
    idle();
    retire_we = 1; retire_dst = 4'd7;
    step();
    retire_we = 0;
    #1;
    // One retire empties R7, so the flushed issue did not increment.
    tests_run++; if (busy_vec !== 16'h0000) begin tests_failed++; $display("FAIL flush_no_inc: got %h expected 0000", busy_vec); end
  endtask

  task automatic test_self_dst();
    idle();
    issue_valid = 1; issue_we = 1; issue_dst = 4'd6; src1 = 4'd6; src1_used = 1;
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL self_first_stall: got %b expected 0", stall); end
    step();
    #1;
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL self_second_stall: got %b expected 1", stall); end
    idle();
    retire_we = 1; retire_dst = 4'd6;
    step();
    idle();
    #1;
    tests_run++; if (busy_vec !== 16'h0000) begin tests_failed++; $display("FAIL self_drain: got %h expected 0000", busy_vec); end
  endtask

  task automatic test_underflow();
    idle();
    issue_valid = 1; issue_we = 1; issue_dst = 4'd4;
    step();
    idle();
    retire_we = 1; retire_dst = 4'd9;
    step();
    idle();
    #1;
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL uf_err_set: got %b expected 1", err); end
    tests_run++; if (busy_vec !== 16'h0010) begin tests_failed++; $display("FAIL uf_busy_vec: got %h expected 0010", busy_vec); end
    retire_we = 1; retire_dst = 4'd4;
    step();
    idle();
    step();
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL uf_err_sticky: got %b expected 1", err); end
    tests_run++; if (busy_vec !== 16'h0000) begin tests_failed++; $display("FAIL uf_drain: got %h expected 0000", busy_vec); end
    do_reset();
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL uf_err_cleared: got %b expected 0", err); end
  endtask

  task automatic test_reset_mid_run();
    idle();
    issue_valid = 1; issue_we = 1; issue_dst = 4'd3;
    step(); step();
    idle();
    #1;
    tests_run++; if (busy_vec !== 16'h0008) begin tests_failed++; $display("FAIL mid_pre_busy_vec: got %h expected 0008", busy_vec); end
    issue_valid = 1; src1 = 4'd3; src1_used = 1;
    #2 rst = 1'b1;
    #1;
    tests_run++; if (busy_vec !== 16'h0000) begin tests_failed++; $display("FAIL mid_async_vec: got %h expected 0000", busy_vec); end
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL mid_async_stall: got %b expected 0", stall); end
    step();
    rst = 1'b0;
    idle();
    retire_we = 1; retire_dst = 4'd3;
    step();
    idle();
    #1;
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL mid_stale_retire_err: got %b expected 1", err); end
  endtask

  initial begin
    idle();
    test_reset();
    test_raw();
    test_saturation();
    test_r0();
    test_flush();
    test_self_dst();
    test_underflow();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
